// File: rtl/gtp_nout_vc_pkg.sv
// Shared types and constants for the GTP network output stage.
// Also holds the team crc16 word-update function (CCITT poly, MSB first).
package gtp_nout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam int          VC_LSB_DEF = 6;
  localparam logic [15:0] CRC_SEED   = 16'h0000;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_CRC        = 3'd1,
    ERR_CRED_FULL  = 3'd2,
    ERR_CRED_SAT   = 3'd3,
    ERR_FRM_VC     = 3'd4,
    ERR_FRM_OVER   = 3'd5,
    ERR_FRM_SOP    = 3'd6,
    ERR_FRM_STRAY  = 3'd7
  } err_cause_e;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } gtp_word_t;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/gtp_nout_vc_if.sv
// GTP back-end / XBI output-port bundle of the network output stage.
interface gtp_nout_vc_if #(
  parameter int NUM_VC = 3,
  parameter int OFF_W  = 6
);
  logic              i_gtp_in_valid;
  logic              i_gtp_in_sop;
  logic              i_gtp_in_eop;
  logic [15:0]       i_gtp_in_data;
  logic [NUM_VC-1:0] o_gtp_in_vc_deq;
  logic [NUM_VC-1:0] o_xbi_nout_enq;
  logic [OFF_W-1:0]  o_xbi_nout_offset;
  logic              o_xbi_nout_eop;
  logic [15:0]       o_xbi_nout_data;
  logic [NUM_VC-1:0] i_xbi_nout_full;
  logic [NUM_VC-1:0] i_xbar_credit;
  logic              o_error_crc;
  logic              o_error_credit;
  logic              o_error_frame;

  modport master (
    output i_gtp_in_valid, i_gtp_in_sop, i_gtp_in_eop, i_gtp_in_data,
    output i_xbi_nout_full, i_xbar_credit,
    input  o_gtp_in_vc_deq, o_xbi_nout_enq, o_xbi_nout_offset, o_xbi_nout_eop,
    input  o_xbi_nout_data, o_error_crc, o_error_credit, o_error_frame
  );

  modport slave (
    input  i_gtp_in_valid, i_gtp_in_sop, i_gtp_in_eop, i_gtp_in_data,
    input  i_xbi_nout_full, i_xbar_credit,
    output o_gtp_in_vc_deq, o_xbi_nout_enq, o_xbi_nout_offset, o_xbi_nout_eop,
    output o_xbi_nout_data, o_error_crc, o_error_credit, o_error_frame
  );
endinterface

// File: rtl/gtp_nout_vc_credit_return_ctr.sv
// One VC's pending-credit counter: accepts up to two credit events per cycle
// and drains them as single-cycle deq pulses, saturating on overflow.
module credit_return_ctr #(
  parameter int PEND_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_xbar,
  input  logic i_local,
  output logic o_deq,
  output logic o_sat
);
  localparam int            TW       = PEND_W + 2;
  localparam logic [TW-1:0] PEND_MAX = TW'((1 << PEND_W) - 1);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              deq_q, deq_d;
  logic [TW-1:0]     tot, rem;

  always_comb begin
    tot    = TW'(pend_q) + TW'(i_xbar) + TW'(i_local);
    deq_d  = (tot != '0);
    rem    = tot - TW'(deq_d);
    pend_d = rem[PEND_W-1:0];
    o_sat  = 1'b0;
    if (rem > PEND_MAX) begin
      pend_d = PEND_MAX[PEND_W-1:0];
      o_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      deq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      deq_q  <= deq_d;
    end
  end

  assign o_deq = deq_q;
endmodule

// File: rtl/gtp_nout_vc.sv
// GTP network output stage: VC decode, CRC16 check, XBI enqueue with abort,
// and lossless per-VC credit return.
module gtp_nout_vc
  import gtp_nout_pkg::*;
#(
  parameter int NUM_VC    = 3,
  parameter int MAX_WORDS = 64,
  parameter int VC_LSB    = VC_LSB_DEF,
  parameter int PEND_W    = 4
) (
  input  logic          clk_gtp,
  input  logic          rst_gtp_n,
  gtp_nout_vc_if.slave  bus
);
  localparam int               OFF_W    = $clog2(MAX_WORDS);
  localparam int               VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MAX_WORDS - 1);

  gtp_word_t         in_w;
  state_e            state_q, state_d;
  logic [NUM_VC-1:0] vc_oh_q, vc_oh_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic [NUM_VC-1:0] enq_q, enq_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [15:0]       data_q, data_d;
  logic              eop_q, eop_d;
  logic              err_crc_q, err_crc_d;
  logic              err_credit_q, err_credit_d;
  logic              err_frame_q, err_frame_d;
  logic              err_full;
  logic [NUM_VC-1:0] local_cr, xbar_cr, deq, sat;
  logic [VC_W-1:0]   vc_fld;
  logic [NUM_VC-1:0] vc_new;
  logic              vc_legal, vc_full;

  assign in_w    = {bus.i_gtp_in_valid, bus.i_gtp_in_sop, bus.i_gtp_in_eop, bus.i_gtp_in_data};
  assign xbar_cr = bus.i_xbar_credit;

  always_comb begin
    vc_fld   = in_w.data[VC_LSB +: VC_W];
    vc_legal = ({1'b0, vc_fld} < (VC_W+1)'(NUM_VC));
    for (int i = 0; i < NUM_VC; i++) vc_new[i] = (vc_fld == VC_W'(i));
    vc_full  = |(vc_new & bus.i_xbi_nout_full);
  end

  always_comb begin
    state_d     = state_q;
    vc_oh_d     = vc_oh_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    enq_d       = (state_q == ST_PASS) ? vc_oh_q : '0;
    off_d       = off_q;
    data_d      = data_q;
    eop_d       = 1'b0;
    err_crc_d   = 1'b0;
    err_full    = 1'b0;
    err_frame_d = 1'b0;
    local_cr    = '0;
    if (in_w.valid) begin
      if (in_w.sop) begin
        // A SOP mid-packet aborts the old packet, then is decoded like a fresh one.
        if (state_q == ST_PASS) begin
          err_frame_d = 1'b1;
          local_cr    = vc_oh_q;
          enq_d       = '0;
        end
        if (!vc_legal) begin
          err_frame_d = 1'b1;
          enq_d       = '0;
          state_d     = in_w.eop ? ST_IDLE : ST_DROP;
        end else if (vc_full) begin
          err_full = 1'b1;
          enq_d    = '0;
          state_d  = in_w.eop ? ST_IDLE : ST_DROP;
        end else begin
          vc_oh_d = vc_new;
          off_d   = '0;
          data_d  = in_w.data;
          cnt_d   = OFF_W'(1);
          crc_d   = crc16_upd(CRC_SEED, in_w.data);
          if (in_w.eop) begin
            // sop+eop word carries only the CRC of an empty body
            state_d = ST_IDLE;
            if (in_w.data == CRC_SEED) begin
              enq_d = vc_new;
              eop_d = 1'b1;
            end else begin
              enq_d     = '0;
              err_crc_d = 1'b1;
              local_cr  = local_cr | vc_new;
            end
          end else begin
            state_d = ST_PASS;
            enq_d   = vc_new;
          end
        end
      end else begin
        case (state_q)
          ST_IDLE: err_frame_d = 1'b1;
          ST_PASS: begin
            if (in_w.eop) begin
              state_d = ST_IDLE;
              off_d   = cnt_q;
              data_d  = in_w.data;
              if (in_w.data == crc_q) begin
                enq_d = vc_oh_q;
                eop_d = 1'b1;
              end else begin
                enq_d     = '0;
                err_crc_d = 1'b1;
                local_cr  = vc_oh_q;
              end
            end else if (cnt_q == LAST_OFF) begin
              // last slot is reserved for the CRC word
              state_d     = ST_DROP;
              enq_d       = '0;
              err_frame_d = 1'b1;
              local_cr    = vc_oh_q;
            end else begin
              enq_d  = vc_oh_q;
              off_d  = cnt_q;
              data_d = in_w.data;
              cnt_d  = cnt_q + OFF_W'(1);
              crc_d  = crc16_upd(crc_q, in_w.data);
            end
          end
          ST_DROP: if (in_w.eop) state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
    err_credit_d = err_full | (|sat);
  end

  always_ff @(posedge clk_gtp) begin
    if (!rst_gtp_n) begin
      state_q      <= ST_IDLE;
      vc_oh_q      <= '0;
      cnt_q        <= '0;
      crc_q        <= CRC_SEED;
      enq_q        <= '0;
      off_q        <= '0;
      data_q       <= '0;
      eop_q        <= 1'b0;
      err_crc_q    <= 1'b0;
      err_credit_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vc_oh_q      <= vc_oh_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      enq_q        <= enq_d;
      off_q        <= off_d;
      data_q       <= data_d;
      eop_q        <= eop_d;
      err_crc_q    <= err_crc_d;
      err_credit_q <= err_credit_d;
      err_frame_q  <= err_frame_d;
    end
  end

  credit_return_ctr #(.PEND_W(PEND_W)) u_cr [NUM_VC-1:0] (
    .clk     (clk_gtp),
    .rst_n   (rst_gtp_n),
    .i_xbar  (xbar_cr),
    .i_local (local_cr),
    .o_deq   (deq),
    .o_sat   (sat)
  );

  assign bus.o_gtp_in_vc_deq   = deq;
  assign bus.o_xbi_nout_enq    = enq_q;
  assign bus.o_xbi_nout_offset = off_q;
  assign bus.o_xbi_nout_eop    = eop_q;
  assign bus.o_xbi_nout_data   = data_q;
  assign bus.o_error_crc       = err_crc_q;
  assign bus.o_error_credit    = err_credit_q;
  assign bus.o_error_frame     = err_frame_q;
endmodule

// File: doc/gtp_nout_vc.md
Name: gtp_nout_vc

Overview:
- Parametrised next-generation GTP network output stage, single clock domain (clk_gtp).
- Takes framed packets from the GTP back end, decodes the VC from the SOP header, checks a trailing CRC16 and writes words into the XBI output port with a per-VC one-hot enqueue.
- Returns per-VC credits to the GTP back end through a lossless pending-credit counter per VC, so coincident credit events are never merged or dropped.
- Adds oversize, framing and invalid-VC detection with packet abort.

Parameters:
- NUM_VC, 3, number of virtual channels (1..8); width of enq/full/deq vectors.
- MAX_WORDS, 64, maximum packet length in words, including the CRC word; OFF_W = clog2(MAX_WORDS).
- VC_LSB, 6, bit position of the VC field in the SOP word; field width VC_W = clog2(NUM_VC), minimum 1.
- PEND_W, 4, width of each per-VC pending-credit counter.

Ports:
- clk_gtp  in  1  clock
- rst_gtp_n  in  1  synchronous reset, active-low
- i_gtp_in_valid  in  1  input word valid
- i_gtp_in_sop  in  1  first word of packet (header)
- i_gtp_in_eop  in  1  last word of packet (CRC16 of all preceding words)
- i_gtp_in_data  in  16  input word
- o_gtp_in_vc_deq  out  NUM_VC  per-VC credit-return pulses
- o_xbi_nout_enq  out  NUM_VC  one-hot enqueue, held for the whole packet
- o_xbi_nout_offset  out  OFF_W  word offset within the packet
- o_xbi_nout_eop  out  1  commit: last word of a CRC-good packet
- o_xbi_nout_data  out  16  word data
- i_xbi_nout_full  in  NUM_VC  per-VC XBI buffer full
- i_xbar_credit  in  NUM_VC  crossbar-side packet dequeued (deq & eop), already in clk_gtp
- o_error_crc  out  1  pulse: CRC mismatch
- o_error_credit  out  1  pulse: SOP to a full VC, or pending-counter saturation
- o_error_frame  out  1  pulse: invalid VC, oversize, SOP mid-packet, or valid word outside a packet

Behaviour:
- Reset: while rst_gtp_n=0 at a clock edge, all outputs go to 0, the FSM goes to IDLE and all pending counters clear. A reset mid-packet discards the packet and returns no credit for it.
- FSM states: IDLE, PASS, DROP.
- IDLE + valid&sop, with a legal VC (field < NUM_VC) whose full bit is 0: go to PASS and latch vc_oh.
- IDLE + valid&sop, VC not full check fails: go to DROP and pulse o_error_credit. No credit is returned.
- IDLE + valid&sop, VC field ≥ NUM_VC: go to DROP and pulse o_error_frame.
- IDLE + valid&~sop: pulse o_error_frame, stay in IDLE.
- A packet that is sop and eop in the same word is a CRC word only. Treat it as oversize=0 and process it as an eop.
- Datapath (PASS, and the SOP cycle that enters PASS):
  - o_xbi_nout_enq=vc_oh, o_xbi_nout_data and o_xbi_nout_offset are registered: one cycle after the input word.
  - Offset is 0 on SOP and increments on each valid word. It holds during gaps; enq stays asserted across valid=0 gaps.
  - The running CRC uses the team's shared crc16 with seed 0 at SOP and updates on every valid non-eop word.
- EOP handling:
  - If the eop word equals the running CRC: o_xbi_nout_eop=1 in the same output cycle as that word, enq is still asserted, then enq=0 next cycle. Go to IDLE.
  - If it does not match: o_error_crc pulses one cycle after the input, eop stays 0, enq deasserts that same cycle, and one local credit for the VC is queued. Go to IDLE.
- Oversize: a valid non-eop word arriving when offset_q = MAX_WORDS-1 aborts the packet. Actions: o_error_frame pulses, enq deasserts without eop, one local credit is queued, go to DROP.
- SOP while in PASS: abort the current packet exactly as for oversize, then evaluate the new SOP as if in IDLE in the same cycle.
- DROP: consume words without enqueueing. An eop returns the FSM to IDLE. A SOP is evaluated as from IDLE; there is no frame error for a SOP in DROP.
- Credit logic, per VC v, each cycle:
  - add = i_xbar_credit[v] + local[v], range 0..2.
  - tot = pend[v] + add.
  - o_gtp_in_vc_deq[v] is registered 1 when tot>0.
  - pend_next = tot - (tot>0).
  - If pend_next exceeds 2^PEND_W-1, saturate and pulse o_error_credit.
  - Latency: one cycle from credit event to deq pulse when no backlog. Back-to-back events drain at one per cycle.
- Simultaneous events: an xbar credit and a local credit on the same VC both count, giving two deq pulses in consecutive cycles.

Decomposition:
- Package gtp_nout_pkg holds:
  - FSM state encoding (IDLE/PASS/DROP);
  - the VC_LSB default;
  - the CRC seed (16'h0000);
  - the error-cause enum used by monitoring.
- Sub-module credit_return_ctr holds one pending-credit counter and pulse generator, parametrised by PEND_W, and is instantiated NUM_VC times.
- The existing crc16 is reused unchanged.

Test Plan:
1. Good packet, VC1, header 16'h0040, 3 data words, correct CRC → enq=3'b010 for 5 cycles; offsets 0..4; eop=1 at offset 4; no errors.
2. Same packet with the CRC word XOR 1 → o_error_crc one pulse; eop never 1; enq drops; o_gtp_in_vc_deq=3'b010 exactly once.
3. SOP to VC0 while i_xbi_nout_full=3'b001 → o_error_credit pulse; enq stays 0 for the packet; no deq pulse.
4. i_xbar_credit[2]=1 on the same cycle as a CRC error on VC2, plus one more xbar credit the next cycle → o_gtp_in_vc_deq[2] high 3 consecutive cycles; pend returns to 0.
5. MAX_WORDS=8; send 10 words without eop, then eop → o_error_frame at word 8; enq deasserts; one VC credit returned; remaining words ignored; FSM back in IDLE.
6. Pull rst_gtp_n low mid-packet with pend=2 → all outputs 0 the next cycle; no deq pulses afterwards; the next SOP is accepted normally.
